// File: rtl/film_scanner_pkg.sv
// Shared film-scanner definitions: framer states, packet sync word, line header layout.
// Latency: none (constants, types and a pure helper function only).
// Backpressure: not applicable.
package film_scanner_pkg;

    // Framer states; each writing state names the word the output register holds.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR_SYNC = 3'd1,
        ST_HDR_LINE = 3'd2,
        ST_PIX      = 3'd3,
        ST_CKSUM    = 3'd4,
        ST_DROP     = 3'd5
    } state_t;

    localparam logic [15:0] SYNC_WORD     = 16'hA55A;
    localparam int          HDR_ABORT_BIT = 15;
    localparam int          HDR_LINE_MSB  = 14;

    // Line header word: abort marker on top, line number underneath.
    function automatic logic [15:0] make_line_hdr(input logic abort_flag,
                                                  input logic [HDR_LINE_MSB:0] line_no);
        logic [15:0] w_hdr;
        w_hdr                   = '0;
        w_hdr[HDR_ABORT_BIT]    = abort_flag;
        w_hdr[HDR_LINE_MSB:0]   = line_no;
        return w_hdr;
    endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// Pixel skid FIFO: synchronous, first-word-fall-through, power-of-2 depth.
// Latency: a push is visible at o_dat the cycle after it is written.
// Backpressure: push on full is dropped unless a pop happens in the same cycle.
module pix_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_pop;
    logic             w_push;

    // Extra pointer bit tells full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_dat   = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO without touching storage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; on full+pop the slot being read is reused by the push.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
    end

endmodule

// File: rtl/line_framer.sv
// CCD line framer: wraps each line as SYNC, header, pixels, checksum into the TX FIFO.
// Latency: sol pixel strobed in cycle N gives the SYNC write in N+2, header N+3, pixel N+4.
// Backpressure: tx_full on a write decision drops the rest of the line; skid overrun sets err_ovf.
module line_framer
    import film_scanner_pkg::*;
#(
    parameter int LINE_PIXELS = 2048,
    parameter int SKID_DEPTH  = 4
) (
    input  logic        clk_160M,
    input  logic        rst,
    input  logic        en,
    input  logic        pix_valid,
    input  logic        pix_sol,
    input  logic [15:0] pix_data,
    input  logic        tx_full,
    output logic        tx_wrreq,
    output logic [15:0] tx_data,
    output logic        busy,
    output logic [15:0] lines_sent,
    output logic [15:0] lines_dropped,
    output logic        err_ovf
);
    localparam logic [15:0] LP = 16'(LINE_PIXELS);

    state_t              r_state;
    logic                r_tx_wrreq;
    logic [15:0]         r_tx_data;
    logic [15:0]         r_sum;
    logic [15:0]         r_pix_cnt;
    logic [HDR_LINE_MSB:0] r_line_no;
    logic                r_abort;
    logic [15:0]         r_lines_sent;
    logic [15:0]         r_lines_dropped;
    logic                r_err_ovf;

    logic [16:0]         w_head;
    logic                w_head_sol;
    logic [15:0]         w_head_dat;
    logic                w_full;
    logic                w_empty;
    logic                w_ovf;
    state_t              w_nxt_state;
    logic                w_pop;
    logic                w_wr;
    logic [15:0]         w_wr_dat;
    logic                w_drop;
    logic                w_sent;
    logic                w_acc;
    logic                w_start;
    logic                w_hdr;

    pix_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (17)
    ) u_skid (
        .i_clk   (clk_160M),
        .i_rst   (rst),
        .i_push  (pix_valid),
        .i_dat   ({pix_sol, pix_data}),
        .i_pop   (w_pop),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_sol    = w_head[16];
    assign w_head_dat    = w_head[15:0];
    assign w_ovf         = pix_valid && w_full && !w_pop;
    assign tx_wrreq      = r_tx_wrreq;
    assign tx_data       = r_tx_data;
    assign busy          = (r_state != ST_IDLE) || !w_empty;
    assign lines_sent    = r_lines_sent;
    assign lines_dropped = r_lines_dropped;
    assign err_ovf       = r_err_ovf;

    // Decide the next word to register, what to pop and which counters move.
    always_comb begin
        w_nxt_state = r_state;
        w_pop       = 1'b0;
        w_wr        = 1'b0;
        w_wr_dat    = '0;
        w_drop      = 1'b0;
        w_sent      = 1'b0;
        w_acc       = 1'b0;
        w_start     = 1'b0;
        w_hdr       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    if (!w_head_sol) begin
                        w_pop = 1'b1;
                    end else if (en && !tx_full) begin
                        // sol entry stays queued: it is the first pixel of the packet
                        w_nxt_state = ST_HDR_SYNC;
                        w_wr        = 1'b1;
                        w_wr_dat    = SYNC_WORD;
                        w_start     = 1'b1;
                    end else begin
                        w_pop       = 1'b1;
                        w_drop      = en;
                        w_nxt_state = ST_DROP;
                    end
                end
            end
            ST_HDR_SYNC: begin
                if (tx_full) begin
                    // head is still this line's sol pixel; discard it with the line
                    w_pop       = !w_empty;
                    w_drop      = 1'b1;
                    w_nxt_state = ST_DROP;
                end else begin
                    w_wr        = 1'b1;
                    w_wr_dat    = make_line_hdr(r_abort, r_line_no);
                    w_hdr       = 1'b1;
                    w_nxt_state = ST_HDR_LINE;
                end
            end
            ST_HDR_LINE, ST_PIX: begin
                w_nxt_state = ST_PIX;
                if (r_pix_cnt == LP) begin
                    if (tx_full) begin
                        w_drop      = 1'b1;
                        w_nxt_state = ST_DROP;
                    end else begin
                        w_wr        = 1'b1;
                        w_wr_dat    = r_sum;
                        w_sent      = 1'b1;
                        w_nxt_state = ST_CKSUM;
                    end
                end else if (!w_empty) begin
                    if (w_head_sol && (r_pix_cnt != '0)) begin
                        // short line: leave the sol queued so it opens the next packet
                        w_drop      = 1'b1;
                        if (tx_full) begin
                            w_nxt_state = ST_DROP;
                        end else begin
                            w_wr        = 1'b1;
                            w_wr_dat    = ~r_sum;
                            w_nxt_state = ST_CKSUM;
                        end
                    end else begin
                        w_pop = 1'b1;
                        if (tx_full) begin
                            w_drop      = 1'b1;
                            w_nxt_state = ST_DROP;
                        end else begin
                            w_wr     = 1'b1;
                            w_wr_dat = w_head_dat;
                            w_acc    = 1'b1;
                        end
                    end
                end
            end
            ST_CKSUM: w_nxt_state = ST_IDLE;
            ST_DROP: begin
                if (!w_empty) begin
                    if (w_head_sol) w_nxt_state = ST_IDLE;
                    else            w_pop       = 1'b1;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    // State, output register, checksum, line numbering and status counters.
    always_ff @(posedge clk_160M) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_tx_wrreq      <= 1'b0;
            r_tx_data       <= '0;
            r_sum           <= '0;
            r_pix_cnt       <= '0;
            r_line_no       <= '0;
            r_abort         <= 1'b0;
            r_lines_sent    <= '0;
            r_lines_dropped <= '0;
            r_err_ovf       <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_tx_wrreq <= w_wr;
            r_tx_data  <= w_wr_dat;
            if (w_start) begin
                r_sum     <= '0;
                r_pix_cnt <= '0;
            end else if (w_acc) begin
                r_sum     <= r_sum + w_head_dat;
                r_pix_cnt <= r_pix_cnt + 16'd1;
            end
            if (w_hdr) begin
                r_abort   <= 1'b0;
                r_line_no <= r_line_no + 1'b1;
            end else if (w_drop) begin
                r_abort   <= 1'b1;
            end
            if (w_drop) r_lines_dropped <= r_lines_dropped + 16'd1;
            if (w_sent) r_lines_sent    <= r_lines_sent + 16'd1;
            if (w_ovf)  r_err_ovf       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_line_framer.sv
// Directed bench for line_framer: expected TX words are queued as stimulus is driven.
// Latency: checks the SYNC/header/pixel timing of the first line explicitly.
// Backpressure: exercises tx_full mid-line, short lines and skid overrun.
module tb_line_framer;
    logic        clk_160M = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_sol = 1'b0;
    logic [15:0] pix_data = '0;
    logic        tx_full = 1'b0;
    logic        tx_wrreq;
    logic [15:0] tx_data;
    logic        busy;
    logic [15:0] lines_sent;
    logic [15:0] lines_dropped;
    logic        err_ovf;

    int          tests = 0;
    int          errs = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    // Shallow skid so that a held-off burst can overrun it.
    line_framer #(
        .LINE_PIXELS (4),
        .SKID_DEPTH  (2)
    ) dut (
        .clk_160M      (clk_160M),
        .rst           (rst),
        .en            (en),
        .pix_valid     (pix_valid),
        .pix_sol       (pix_sol),
        .pix_data      (pix_data),
        .tx_full       (tx_full),
        .tx_wrreq      (tx_wrreq),
        .tx_data       (tx_data),
        .busy          (busy),
        .lines_sent    (lines_sent),
        .lines_dropped (lines_dropped),
        .err_ovf       (err_ovf)
    );

    always #5 clk_160M = ~clk_160M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every TX write must match the oldest queued expectation.
    always @(negedge clk_160M) begin
        if (!rst && tx_wrreq) begin
            chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                chk("tx_data", {16'h0, tx_data}, {16'h0, mon_exp});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_160M);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_pix(input logic sol, input logic [15:0] d);
        pix_valid = 1'b1;
        pix_sol   = sol;
        pix_data  = d;
        tick();
        pix_valid = 1'b0;
        pix_sol   = 1'b0;
    endtask

    task automatic send_line(input logic [15:0] p0, input logic [15:0] p1,
                             input logic [15:0] p2, input logic [15:0] p3);
        send_pix(1'b1, p0); idle(7);
        send_pix(1'b0, p1); idle(7);
        send_pix(1'b0, p2); idle(7);
        send_pix(1'b0, p3); idle(7);
    endtask

    task automatic exp_line(input logic [15:0] hdr, input logic [15:0] p0, input logic [15:0] p1,
                            input logic [15:0] p2, input logic [15:0] p3);
        exp_q.push_back(16'hA55A);
        exp_q.push_back(hdr);
        exp_q.push_back(p0);
        exp_q.push_back(p1);
        exp_q.push_back(p2);
        exp_q.push_back(p3);
        exp_q.push_back(p0 + p1 + p2 + p3);
    endtask

    task automatic do_reset();
        exp_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        idle(6);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        idle(2);
        do_reset();
        chk("rst_wrreq", 32'(tx_wrreq), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sent", 32'(lines_sent), 32'd0);
        chk("rst_dropped", 32'(lines_dropped), 32'd0);
        chk("rst_ovf", 32'(err_ovf), 32'd0);

        // Normal line with explicit latency points.
        exp_line(16'h0000, 16'd1, 16'd2, 16'd3, 16'd4);
        send_pix(1'b1, 16'd1);
        chk("lat_n1_wrreq", 32'(tx_wrreq), 32'd0);
        chk("lat_n1_busy", 32'(busy), 32'd1);
        tick();
        chk("lat_n2_wrreq", 32'(tx_wrreq), 32'd1);
        chk("lat_n2_sync", 32'(tx_data), 32'hA55A);
        tick();
        chk("lat_n3_hdr", 32'(tx_data), 32'h0000);
        tick();
        chk("lat_n4_pix", 32'(tx_data), 32'h0001);
        idle(4);
        send_pix(1'b0, 16'd2); idle(7);
        send_pix(1'b0, 16'd3); idle(7);
        send_pix(1'b0, 16'd4); idle(7);
        drain("normal_drain");
        chk("normal_sent", 32'(lines_sent), 32'd1);
        chk("normal_dropped", 32'(lines_dropped), 32'd0);
        chk("normal_busy", 32'(busy), 32'd0);

        // Back-to-back lines; en drops mid-way through the second one.
        do_reset();
        exp_line(16'h0000, 16'd1, 16'd2, 16'd3, 16'd4);
        exp_line(16'h0001, 16'h1000, 16'h2000, 16'h0300, 16'hFFFF);
        send_line(16'd1, 16'd2, 16'd3, 16'd4);
        send_pix(1'b1, 16'h1000); idle(3);
        en = 1'b0;
        idle(4);
        send_pix(1'b0, 16'h2000); idle(7);
        send_pix(1'b0, 16'h0300); idle(7);
        send_pix(1'b0, 16'hFFFF); idle(7);
        drain("b2b_drain");
        en = 1'b1;
        chk("b2b_sent", 32'(lines_sent), 32'd2);
        chk("b2b_dropped", 32'(lines_dropped), 32'd0);

        // Short line followed by a full one.
        do_reset();
        exp_q.push_back(16'hA55A);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'd5);
        exp_q.push_back(16'd6);
        exp_q.push_back(16'hFFF4);
        exp_line(16'h8001, 16'd1, 16'd2, 16'd3, 16'd4);
        send_pix(1'b1, 16'd5); idle(7);
        send_pix(1'b0, 16'd6); idle(7);
        send_line(16'd1, 16'd2, 16'd3, 16'd4);
        drain("short_drain");
        chk("short_dropped", 32'(lines_dropped), 32'd1);
        chk("short_sent", 32'(lines_sent), 32'd1);

        // TX FIFO full while pixel 3 is pending.
        do_reset();
        exp_q.push_back(16'hA55A);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'd1);
        exp_q.push_back(16'd2);
        exp_line(16'h8001, 16'd1, 16'd2, 16'd3, 16'd4);
        send_pix(1'b1, 16'd1); idle(7);
        send_pix(1'b0, 16'd2); idle(7);
        tx_full = 1'b1;
        send_pix(1'b0, 16'd3); idle(3);
        tx_full = 1'b0;
        idle(4);
        send_pix(1'b0, 16'd4); idle(7);
        send_line(16'd1, 16'd2, 16'd3, 16'd4);
        drain("full_drain");
        chk("full_dropped", 32'(lines_dropped), 32'd1);
        chk("full_sent", 32'(lines_sent), 32'd1);
        chk("full_no_ovf", 32'(err_ovf), 32'd0);

        // Skid overrun: five sol pixels back to back while TX is held off.
        do_reset();
        tx_full = 1'b1;
        for (int i = 0; i < 5; i++) send_pix(1'b1, 16'(i + 16'h40));
        idle(10);
        tx_full = 1'b0;
        idle(4);
        chk("ovf_flag", 32'(err_ovf), 32'd1);
        chk("ovf_dropped", 32'(lines_dropped), 32'd4);
        chk("ovf_sent", 32'(lines_sent), 32'd0);
        chk("ovf_busy_drop", 32'(busy), 32'd1);
        chk("ovf_no_writes", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a packet.
        do_reset();
        chk("ovf_cleared", 32'(err_ovf), 32'd0);
        exp_q.push_back(16'hA55A);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'd1);
        exp_q.push_back(16'd2);
        send_pix(1'b1, 16'd1); idle(7);
        send_pix(1'b0, 16'd2); idle(3);
        chk("mid_pix_q", 32'(exp_q.size()), 32'd0);
        do_reset();
        chk("mid_rst_wrreq", 32'(tx_wrreq), 32'd0);
        chk("mid_rst_sent", 32'(lines_sent), 32'd0);
        chk("mid_rst_dropped", 32'(lines_dropped), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        exp_line(16'h0000, 16'd7, 16'd8, 16'd9, 16'd10);
        send_line(16'd7, 16'd8, 16'd9, 16'd10);
        drain("rst_drain");
        chk("rst_line_sent", 32'(lines_sent), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule

// File: doc/line_framer.md
LINE_FRAMER -- requirements
Module: line_framer

Interface
REQ-001 SHALL have parameter LINE_PIXELS, default 2048, pixels per CCD line (range 2..32767).
REQ-002 SHALL have parameter SKID_DEPTH, default 4, input skid FIFO entries (power of 2).
REQ-003 SHALL have port clk_160M  input  1  single clock for all logic (one clock).
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  scan enable; a new line is framed only while high.
REQ-006 SHALL have port pix_valid  input  1  one-cycle strobe; pixel word present.
REQ-007 SHALL have port pix_sol  input  1  qualifies pix_valid; marks the line's first pixel.
REQ-008 SHALL have port pix_data  input  16  ADC pixel sample.
REQ-009 SHALL have port tx_full  input  1  downstream TX FIFO full.
REQ-010 SHALL have port tx_wrreq  output  1  registered write strobe to the TX FIFO.
REQ-011 SHALL have port tx_data  output  16  registered word, valid while tx_wrreq is high.
REQ-012 SHALL have port busy  output  1  high when the state is not IDLE or the skid FIFO is non-empty.
REQ-013 SHALL have port lines_sent  output  16  count of completed packets, wraps at 2^16.
REQ-014 SHALL have port lines_dropped  output  16  count of dropped or aborted lines, wraps at 2^16.
REQ-015 SHALL have port err_ovf  output  1  sticky; a pixel arrived while the skid FIFO was full.

Function
REQ-016 Each pixel with pix_valid=1 SHALL be pushed into the skid FIFO as {pix_sol, pix_data}.
- If the FIFO is full, the pixel is discarded and err_ovf is set.
REQ-017 The FSM SHALL have states IDLE, HDR_SYNC, HDR_LINE, PIX, CKSUM and DROP.
- Exactly one word is written per cycle, only in HDR_SYNC, HDR_LINE, PIX and CKSUM.
REQ-018 IDLE, head entry with sol=1, en=1 and tx_full=0: the FSM SHALL go to HDR_SYNC.
- With en=0 or tx_full=1, the head entry is popped, lines_dropped increments (en=1 only), and the FSM goes to DROP.
- A head entry with sol=0 is popped and discarded.
REQ-019 HDR_SYNC SHALL write 16'hA55A.
REQ-020 HDR_LINE SHALL write {abort_flag, line_no[14:0]}.
- abort_flag is set when the previous line was dropped or aborted, and is cleared by this write.
- line_no increments after each HDR_LINE and wraps at 2^15.
REQ-021 PIX SHALL pop and write one pixel per cycle while the FIFO is non-empty.
- Each written pixel is added to a 16-bit modulo sum that is zeroed at HDR_SYNC.
- After LINE_PIXELS pixels the FSM goes to CKSUM.
REQ-022 CKSUM SHALL write sum and increment lines_sent, then go to IDLE.
REQ-023 A sol=1 head entry in PIX before LINE_PIXELS pixels (short line) SHALL NOT be popped.
- The FSM writes ~sum in CKSUM, sets abort_flag, increments lines_dropped, and re-enters IDLE so the entry opens the next packet.
REQ-024 tx_full=1 on any write cycle SHALL suppress that write.
- The FSM goes to DROP, sets abort_flag and increments lines_dropped.
REQ-025 DROP SHALL pop and discard entries until the head has sol=1, then return to IDLE.
REQ-026 en falling mid-line SHALL NOT affect the current packet; it completes normally.
REQ-027 Latency: a sol pixel strobed in cycle N with an empty FIFO and IDLE state SHALL produce tx_wrreq with 16'hA55A in cycle N+2.
- The line word follows in N+3 and the first pixel in N+4.
REQ-028 Simultaneous push and pop on a full FIFO SHALL accept the push.

Reset
REQ-029 While rst=1 at a clk_160M edge, the block SHALL enter IDLE with all internal state and outputs cleared:
- skid FIFO emptied; line_no, sum, abort_flag, lines_sent, lines_dropped and err_ovf cleared; tx_wrreq=0, tx_data=0, busy=0.
REQ-030 Reset mid-packet SHALL abandon the packet without a checksum word.

Structure
REQ-031 The state enum, the SYNC word constant 16'hA55A and the header bit positions SHALL reside in the shared package film_scanner_pkg.
REQ-032 The skid FIFO SHALL be the sub-module pix_skid_fifo (synchronous, first-word-fall-through, full/empty flags).

Verification
REQ-033 The bench SHALL cover these directed scenarios, all with LINE_PIXELS=4:
- Normal line: sol line 1,2,3,4 at 8-cycle spacing, en=1 -> A55A, 0000, 1, 2, 3, 4, 000A; lines_sent=1.
- Back-to-back lines: two lines -> second header 0001; sums correct.
- Short line: pixels 5,6 then a new sol line -> writes ~000B=FFF4, then A55A, 8001; lines_dropped=1.
- Full mid-line: tx_full=1 while pixel 3 pending -> no further writes until the next sol; next header has bit15=1.
- Overflow: 5 pixels in consecutive cycles with tx_full held -> err_ovf=1.
- Reset mid-PIX: rst for 1 cycle -> tx_wrreq=0 next cycle, counters 0; next line header 0000.
